// File: rtl/reg_port_arbiter_pkg.sv
// Shared types and constants for the register-port arbiter.
package reg_port_arbiter_pkg;

    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_W1 = 2'd1,
        GNT_W2 = 2'd2,
        GNT_RD = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between the writers; owns the wr_ptr flop.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req_1,
    input  logic req_2,
    input  logic take,
    output logic sel_2
);

    logic wr_ptr_q;
    logic wr_ptr_d;

    always_comb begin
        sel_2    = (req_1 && req_2) ? wr_ptr_q : req_2;
        wr_ptr_d = wr_ptr_q;
        // After a grant the pointer favours the writer that lost.
        if (take) begin
            wr_ptr_d = ~sel_2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
        end
    end

endmodule

// File: rtl/reg_port_arbiter.sv
// Single-word register shared by two writers and one reader, one grant at a time.
// Optional write-grant counter enabled by defining REG_PORT_ARBITER_WRCNT_EN.
module reg_port_arbiter
    import reg_port_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req_1,
    input  logic [DATA_W-1:0] wr_data_1,
    input  logic              wr_req_2,
    input  logic [DATA_W-1:0] wr_data_2,
    input  logic              rd_req,
    output logic              wr_gnt_1,
    output logic              wr_gnt_2,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
`ifdef REG_PORT_ARBITER_WRCNT_EN
    ,
    output logic [7:0]        wr_count
`endif
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   storage_q, storage_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                last_rd_q, last_rd_d;
    logic                gnt_1_q, gnt_1_d;
    logic                gnt_2_q, gnt_2_d;
    logic                busy_q, busy_d;
    logic                wr_any;
    logic                take;
    logic                sel_2;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .reset (reset),
        .req_1 (wr_req_1),
        .req_2 (wr_req_2),
        .take  (take),
        .sel_2 (sel_2)
    );

    always_comb begin
        state_d    = state_q;
        storage_d  = storage_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        last_rd_d  = last_rd_q;
        take       = 1'b0;
        wr_any     = wr_req_1 || wr_req_2;
        case (state_q)
            IDLE: begin
                // A read wins a tie only if the previous grant was a write.
                if (rd_req && (!wr_any || !last_rd_q)) begin
                    state_d   = GNT_RD;
                    last_rd_d = 1'b1;
                end else if (wr_any) begin
                    take      = 1'b1;
                    state_d   = sel_2 ? GNT_W2 : GNT_W1;
                    last_rd_d = 1'b0;
                end
            end
            GNT_W1: begin
                storage_d = wr_data_1;
                state_d   = IDLE;
            end
            GNT_W2: begin
                storage_d = wr_data_2;
                state_d   = IDLE;
            end
            GNT_RD: begin
                rd_data_d  = storage_q;
                rd_valid_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        gnt_1_d = (state_d == GNT_W1);
        gnt_2_d = (state_d == GNT_W2);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            storage_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            last_rd_q  <= 1'b0;
            gnt_1_q    <= 1'b0;
            gnt_2_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            storage_q  <= storage_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            last_rd_q  <= last_rd_d;
            gnt_1_q    <= gnt_1_d;
            gnt_2_q    <= gnt_2_d;
            busy_q     <= busy_d;
        end
    end

    assign wr_gnt_1 = gnt_1_q;
    assign wr_gnt_2 = gnt_2_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign busy     = busy_q;

`ifdef REG_PORT_ARBITER_WRCNT_EN
    logic [7:0] wr_count_q, wr_count_d;

    always_comb begin
        wr_count_d = wr_count_q;
        if (take && (wr_count_q != 8'hFF)) begin
            wr_count_d = wr_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_count_q <= 8'd0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count = wr_count_q;
`endif

endmodule
